// File: rtl/vx_ti_stack_arb_pkg.sv
// Shared types and sizing for the traversal-stack arbiter: op/status encodings,
// the request record and the derived field widths.
package vx_ti_stack_arb_pkg;

  localparam int NUM_REQS   = 4;
  localparam int NUM_RAYS   = 8;
  localparam int STACK_SIZE = 32;
  localparam int ENTRY_BITS = 32;

  localparam int REQ_W = $clog2(NUM_REQS);
  localparam int RAY_W = $clog2(NUM_RAYS);
  localparam int SP_W  = $clog2(STACK_SIZE) + 1;

  typedef enum logic [1:0] {
    OP_PUSH  = 2'd0,
    OP_POP   = 2'd1,
    OP_PEEK  = 2'd2,
    OP_CLEAR = 2'd3
  } ti_stack_op_e;

  typedef enum logic [1:0] {
    ST_OK        = 2'd0,
    ST_UNDERFLOW = 2'd1,
    ST_OVERFLOW  = 2'd2
  } ti_stack_status_e;

  typedef struct packed {
    ti_stack_op_e          op;
    logic [RAY_W-1:0]      ray_id;
    logic [ENTRY_BITS-1:0] data;
  } ti_stack_req_t;

endpackage

// File: rtl/vx_ti_stack_arb_if.sv
// Request/response bundle between the traversal requesters and the stack arbiter.
// Handshake: a request (or response) transfers on a rising edge where valid and
// ready are both high; valid and payload must hold until that edge.
interface vx_ti_stack_arb_if;
  import vx_ti_stack_arb_pkg::*;

  logic [NUM_REQS-1:0]            req_valid;
  logic [NUM_REQS*2-1:0]          req_op;
  logic [NUM_REQS*RAY_W-1:0]      req_ray_id;
  logic [NUM_REQS*ENTRY_BITS-1:0] req_data;
  logic [NUM_REQS-1:0]            req_ready;

  logic                  rsp_valid;
  logic [REQ_W-1:0]      rsp_req_idx;
  logic [1:0]            rsp_op;
  logic [1:0]            rsp_status;
  logic [ENTRY_BITS-1:0] rsp_data;
  logic [SP_W-1:0]       rsp_depth;
  logic                  rsp_ready;

  modport master (
    output req_valid, req_op, req_ray_id, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_req_idx, rsp_op, rsp_status, rsp_data, rsp_depth
  );

  modport slave (
    input  req_valid, req_op, req_ray_id, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_req_idx, rsp_op, rsp_status, rsp_data, rsp_depth
  );
endinterface

// File: rtl/vx_ti_stack_arb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at the priority pointer,
// which moves just past the winner after every grant.
module vx_ti_stack_arb_rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [N-1:0]  valid,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  logic [IW-1:0] ptr;
  logic          found;

  // Scan downward so the candidate closest to the pointer is written last and wins.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (valid[IW'((int'(ptr) + k) % N)]) begin
        found     = 1'b1;
        grant_idx = IW'((int'(ptr) + k) % N);
      end
    end
    grant_valid = en && found;
    grant       = '0;
    if (grant_valid) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/vx_ti_stack_arb.sv
// Shared traversal-stack controller: arbitrates stack ops onto one flat RAM split
// into per-ray LIFOs, owns the stack pointers and returns one registered response per grant.
module vx_ti_stack_arb
  import vx_ti_stack_arb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  vx_ti_stack_arb_if.slave bus,
  output logic             busy
);

  localparam int IDX_W = SP_W - 1;
  localparam int DEPTH = NUM_RAYS * STACK_SIZE;

  logic [SP_W-1:0]       sp [NUM_RAYS];
  logic [ENTRY_BITS-1:0] mem [DEPTH];
  logic [ENTRY_BITS-1:0] rd_q;
  logic                  rsp_rd_ok;

  logic                  grant_en, fire;
  logic [NUM_REQS-1:0]   gnt;
  logic [REQ_W-1:0]      gnt_idx;
  ti_stack_req_t         req;
  logic [SP_W-1:0]       cur_sp, sp_dec, nxt_sp;
  ti_stack_status_e      status;
  logic                  wr_en, rd_ok;
  logic [IDX_W-1:0]      slot;
  logic [RAY_W+IDX_W-1:0] addr;

  // A new op may only enter when the response register is free or draining this cycle.
  assign grant_en = reset && (!bus.rsp_valid || bus.rsp_ready) && !flush;

  vx_ti_stack_arb_rr_arbiter #(.N(NUM_REQS)) u_arb (
    .clk         (clk),
    .reset       (reset),
    .en          (grant_en),
    .valid       (bus.req_valid),
    .grant       (gnt),
    .grant_idx   (gnt_idx),
    .grant_valid (fire)
  );

  assign bus.req_ready = gnt;

  always_comb begin
    req.op     = ti_stack_op_e'(bus.req_op[gnt_idx*2 +: 2]);
    req.ray_id = bus.req_ray_id[gnt_idx*RAY_W +: RAY_W];
    req.data   = bus.req_data[gnt_idx*ENTRY_BITS +: ENTRY_BITS];
  end

  assign cur_sp = sp[req.ray_id];
  assign sp_dec = cur_sp - 1'b1;

  always_comb begin
    nxt_sp = cur_sp;
    status = ST_OK;
    wr_en  = 1'b0;
    rd_ok  = 1'b0;
    slot   = cur_sp[IDX_W-1:0];
    case (req.op)
      OP_PUSH: begin
        if (cur_sp == SP_W'(STACK_SIZE)) begin
          status = ST_OVERFLOW;
        end else begin
          wr_en  = 1'b1;
          nxt_sp = cur_sp + 1'b1;
        end
      end
      OP_POP, OP_PEEK: begin
        slot = sp_dec[IDX_W-1:0];
        if (cur_sp == '0) begin
          status = ST_UNDERFLOW;
        end else begin
          rd_ok = 1'b1;
          if (req.op == OP_POP) nxt_sp = sp_dec;
        end
      end
      default: nxt_sp = '0;
    endcase
  end

  // STACK_SIZE is a power of two, so concatenation equals ray_id*STACK_SIZE + slot.
  assign addr = {req.ray_id, slot};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_RAYS; r++) sp[r] <= '0;
    end else if (flush) begin
      for (int r = 0; r < NUM_RAYS; r++) sp[r] <= '0;
    end else if (fire) begin
      sp[req.ray_id] <= nxt_sp;
    end
  end

  // Storage is left unreset; rd_q only changes on a grant so a stalled response stays put.
  always_ff @(posedge clk) begin
    if (fire && wr_en) mem[addr] <= req.data;
    if (fire) rd_q <= mem[addr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.rsp_valid   <= 1'b0;
      bus.rsp_req_idx <= '0;
      bus.rsp_op      <= '0;
      bus.rsp_status  <= '0;
      bus.rsp_depth   <= '0;
      rsp_rd_ok       <= 1'b0;
    end else if (fire) begin
      bus.rsp_valid   <= 1'b1;
      bus.rsp_req_idx <= gnt_idx;
      bus.rsp_op      <= req.op;
      bus.rsp_status  <= status;
      bus.rsp_depth   <= nxt_sp;
      rsp_rd_ok       <= rd_ok;
    end else if (bus.rsp_ready) begin
      bus.rsp_valid   <= 1'b0;
    end
  end

  assign bus.rsp_data = rsp_rd_ok ? rd_q : '0;
  assign busy         = bus.rsp_valid | (|bus.req_valid);

endmodule

// File: tb/tb_vx_ti_stack_arb.sv
// Bench for the traversal-stack arbiter: queued requesters, a queue-based stack
// reference with its own round-robin model, and a response scoreboard.
module tb_vx_ti_stack_arb;
  import vx_ti_stack_arb_pkg::*;

  localparam int RSP_W = REQ_W + 2 + 2 + ENTRY_BITS + SP_W;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  logic busy;

  vx_ti_stack_arb_if bus();

  vx_ti_stack_arb dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus),
    .busy  (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [RSP_W-1:0]      exp_q [$];
  ti_stack_req_t         drv_q [NUM_REQS][$];
  logic [ENTRY_BITS-1:0] m_stk [NUM_RAYS][$];
  int                    m_ptr = 0;
  bit                    m_pending = 0;
  bit                    rdy_rand = 0;
  bit                    rdy_hold = 0;
  bit                    held_valid = 0;
  logic [RSP_W-1:0]      held_rsp;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [RSP_W-1:0] pack(input logic [REQ_W-1:0] idx, input logic [1:0] op,
                                            input logic [1:0] st, input logic [ENTRY_BITS-1:0] d,
                                            input logic [SP_W-1:0] dep);
    return {idx, op, st, d, dep};
  endfunction

  function automatic logic [RSP_W-1:0] dut_rsp();
    return {bus.rsp_req_idx, bus.rsp_op, bus.rsp_status, bus.rsp_data, bus.rsp_depth};
  endfunction

  // ---------------- driver ----------------
  task automatic enq(input int r, input ti_stack_op_e op, input int ray, input logic [ENTRY_BITS-1:0] d);
    ti_stack_req_t t;
    t.op     = op;
    t.ray_id = RAY_W'(ray);
    t.data   = d;
    drv_q[r].push_back(t);
  endtask

  initial begin : driver
    logic [NUM_REQS-1:0] hs;
    bus.req_valid  = '0;
    bus.req_op     = '0;
    bus.req_ray_id = '0;
    bus.req_data   = '0;
    bus.rsp_ready  = 1'b1;
    forever begin
      @(negedge clk);
      hs = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      for (int r = 0; r < NUM_REQS; r++) begin
        if (hs[r] && reset && drv_q[r].size() > 0) void'(drv_q[r].pop_front());
        if (drv_q[r].size() > 0) begin
          bus.req_valid[r]                       = 1'b1;
          bus.req_op[r*2 +: 2]                   = drv_q[r][0].op;
          bus.req_ray_id[r*RAY_W +: RAY_W]       = drv_q[r][0].ray_id;
          bus.req_data[r*ENTRY_BITS +: ENTRY_BITS] = drv_q[r][0].data;
        end else begin
          bus.req_valid[r] = 1'b0;
        end
      end
      bus.rsp_ready = rdy_hold ? 1'b0 : (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  // ---------------- reference model: arbitration + per-ray stacks ----------------
  int                    g;
  int                    c;
  logic [1:0]            m_op;
  int                    m_ray;
  logic [ENTRY_BITS-1:0] m_d;
  logic [ENTRY_BITS-1:0] m_rd;
  logic [1:0]            m_st;
  logic [NUM_REQS-1:0]   exp_rdy;

  always @(negedge clk) begin
    if (reset) begin
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_pending));
      g = -1;
      if ((!m_pending || bus.rsp_ready) && !flush) begin
        for (int k = 0; k < NUM_REQS; k++) begin
          c = (m_ptr + k) % NUM_REQS;
          if (g < 0 && bus.req_valid[c]) g = c;
        end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      if (g >= 0) begin
        m_op  = bus.req_op[g*2 +: 2];
        m_ray = int'(bus.req_ray_id[g*RAY_W +: RAY_W]);
        m_d   = bus.req_data[g*ENTRY_BITS +: ENTRY_BITS];
        m_rd  = '0;
        m_st  = 2'd0;
        case (m_op)
          2'd0: if (m_stk[m_ray].size() == STACK_SIZE) m_st = 2'd2;
                else m_stk[m_ray].push_back(m_d);
          2'd1: if (m_stk[m_ray].size() == 0) m_st = 2'd1;
                else m_rd = m_stk[m_ray].pop_back();
          2'd2: if (m_stk[m_ray].size() == 0) m_st = 2'd1;
                else m_rd = m_stk[m_ray][$];
          default: m_stk[m_ray].delete();
        endcase
        exp_q.push_back(pack(REQ_W'(g), m_op, m_st, m_rd, SP_W'(m_stk[m_ray].size())));
        m_ptr     = (g + 1) % NUM_REQS;
        m_pending = 1'b1;
      end else if (bus.rsp_ready) begin
        m_pending = 1'b0;
      end
      if (flush) for (int r = 0; r < NUM_RAYS; r++) m_stk[r].delete();
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      held_valid = 1'b0;
    end else begin
      if (held_valid) chk("rsp_stable", 64'({bus.rsp_valid, dut_rsp()}), 64'({1'b1, held_rsp}));
      held_valid = 1'b0;
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL rsp_unexpected: got %0h required no response", dut_rsp());
        end else begin
          chk("rsp", 64'(dut_rsp()), 64'(exp_q.pop_front()));
        end
      end else if (bus.rsp_valid) begin
        held_valid = 1'b1;
        held_rsp   = dut_rsp();
      end
    end
  end

  // ---------------- sequencing helpers ----------------
  function automatic bit all_idle();
    bit idle = (exp_q.size() == 0) && !m_pending;
    for (int r = 0; r < NUM_REQS; r++) if (drv_q[r].size() != 0) idle = 1'b0;
    return idle;
  endfunction

  task automatic drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge clk);
      if (all_idle()) done = 1'b1;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL drain_%s: still busy after 3000 cycles, required idle", name);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    flush = 1'b0;
    for (int r = 0; r < NUM_REQS; r++) drv_q[r].delete();
    for (int r = 0; r < NUM_RAYS; r++) m_stk[r].delete();
    bus.req_valid = '0;
    exp_q.delete();
    m_pending  = 1'b0;
    m_ptr      = 0;
    held_valid = 1'b0;
    #1;
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("reset_rsp_depth", 64'(bus.rsp_depth), 64'(0));
    @(negedge clk);
    #2 reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid",  64'(bus.rsp_valid), 64'(0));
    chk("rst_req_ready",  64'(bus.req_ready), 64'(0));
    chk("rst_rsp_fields", 64'(dut_rsp()), 64'(0));
    chk("rst_busy",       64'(busy), 64'(0));
    #2 reset = 1'b1;

    // push 0xA, 0xB to ray 3 then pop twice
    enq(0, OP_PUSH, 3, 32'hA);
    enq(0, OP_PUSH, 3, 32'hB);
    enq(0, OP_POP,  3, 32'h0);
    enq(0, OP_POP,  3, 32'h0);
    drain("lifo");

    // all four requesters contend: grants 0,1,2,3,0
    do_reset();
    for (int r = 0; r < NUM_REQS; r++) enq(r, OP_PUSH, 6, 32'h100 + r);
    enq(0, OP_POP, 6, 32'h0);
    drain("rr");

    // fill ray 5, overflow, underflow on empty ray 2, then top must be the 32nd entry
    for (int i = 0; i < STACK_SIZE + 1; i++) enq(1, OP_PUSH, 5, 32'h5000 + i);
    enq(2, OP_POP, 2, 32'h0);
    drain("fill");
    enq(1, OP_PEEK, 5, 32'h0);
    enq(1, OP_POP,  5, 32'h0);
    drain("after_overflow");

    // response stall with requests pending
    rdy_hold = 1'b1;
    for (int i = 0; i < 3; i++) enq(3, OP_PUSH, 4, 32'h4400 + i);
    enq(0, OP_PEEK, 4, 32'h0);
    repeat (5) @(posedge clk);
    rdy_hold = 1'b0;
    drain("stall");

    // back-to-back push then peek on the same ray
    enq(0, OP_CLEAR, 1, 32'h0);
    enq(0, OP_PUSH,  1, 32'h11);
    enq(0, OP_PEEK,  1, 32'h0);
    drain("b2b");

    // flush clears every ray
    enq(0, OP_PUSH, 0, 32'hA0);
    enq(1, OP_PUSH, 7, 32'hA7);
    drain("pre_flush");
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    enq(2, OP_POP, 0, 32'h0);
    enq(3, OP_POP, 7, 32'h0);
    drain("flush");

    // randomized traffic with random back-pressure and occasional flush
    rdy_rand = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk);
      #1;
      flush = ($urandom_range(0, 39) == 0);
      for (int r = 0; r < NUM_REQS; r++) begin
        if (drv_q[r].size() < 2 && $urandom_range(0, 2) == 0) begin
          int w = $urandom_range(0, 9);
          ti_stack_op_e op = (w < 5) ? OP_PUSH : (w < 7) ? OP_POP : (w < 9) ? OP_PEEK : OP_CLEAR;
          enq(r, op, $urandom_range(0, NUM_RAYS - 1), $urandom);
        end
      end
    end
    @(posedge clk); #1 flush = 1'b0;
    drain("random");
    rdy_rand = 1'b0;

    // reset in the middle of traffic
    for (int r = 0; r < NUM_REQS; r++) begin
      enq(r, OP_PUSH, r, 32'hBEEF0 + r);
      enq(r, OP_PUSH, 0, 32'hCAFE0 + r);
    end
    repeat (3) @(posedge clk);
    #3;
    do_reset();
    enq(0, OP_POP, 0, 32'h0);
    enq(1, OP_PEEK, 1, 32'h0);
    drain("post_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vx_ti_stack_arb.md
# VX_ti_stack_arb

Shared traversal-stack controller for the ray-tracing unit. It arbitrates push, pop, peek and clear requests from several traversal requesters onto one flat stack RAM, which is partitioned into per-ray LIFO stacks. It owns all per-ray stack pointers, applies overflow and underflow policy, and returns one registered response per granted request. It sits between the traversal/intersection pipelines and the stack storage.

## Interface
- NUM_REQS, 4, number of requesters.
- NUM_RAYS, 8, number of independent per-ray stacks.
- STACK_SIZE, 32, entries per ray stack (power of two).
- ENTRY_BITS, 32, width of a stack entry (node pointer/metadata).
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  clear all ray stack pointers in one cycle.
- req_valid  in  NUM_REQS  per-requester request valid.
- req_op  in  NUM_REQS*2  op per requester: PUSH=0, POP=1, PEEK=2, CLEAR=3.
- req_ray_id  in  NUM_REQS*log2(NUM_RAYS)  target ray stack.
- req_data  in  NUM_REQS*ENTRY_BITS  push data.
- req_ready  out  NUM_REQS  one-hot grant; the request is consumed when valid&ready.
- rsp_valid  out  1  response valid.
- rsp_req_idx  out  log2(NUM_REQS)  requester that owns the response.
- rsp_op  out  2  echoed op.
- rsp_status  out  2  OK=0, UNDERFLOW=1, OVERFLOW=2.
- rsp_data  out  ENTRY_BITS  popped/peeked entry; 0 for PUSH/CLEAR or on error.
- rsp_depth  out  log2(STACK_SIZE)+1  ray stack depth after the op.
- rsp_ready  in  1  response consumer ready.
- busy  out  1  rsp_valid or any req_valid.

## Operation
- Storage: NUM_RAYS*STACK_SIZE entries. The address is ray_id*STACK_SIZE + index. The RAM is not reset.
- Per-ray pointer sp[r] has width log2(STACK_SIZE)+1 and range 0..STACK_SIZE. Empty is sp==0; full is sp==STACK_SIZE.
- Arbitration: round-robin over req_valid, starting at the priority pointer. After a grant of requester i, the pointer becomes (i+1) mod NUM_REQS. The pointer resets to 0.
- A grant is issued only when (!rsp_valid || rsp_ready) and !flush. At most one grant per cycle.
- PUSH:
  - not full: write mem[r][sp], sp+1, OK.
  - full: no write, sp unchanged, OVERFLOW.
- POP:
  - not empty: read mem[r][sp-1], sp-1, OK.
  - empty: rsp_data=0, UNDERFLOW.
- PEEK: same read as POP, sp unchanged; UNDERFLOW if empty.
- CLEAR: sp[r]=0, OK, rsp_depth=0.
- flush: all sp=0 at the next edge. No grant that cycle. A pending response is unaffected.
- Requests to the same ray from different requesters are serialized by arbitration. Order follows grant order.
- A request for a ray that was granted in the previous cycle sees the updated sp and RAM. No extra hazard stall is allowed.

## Timing
- Reset values: rsp_valid=0, rsp_req_idx=0, rsp_op=0, rsp_status=0, rsp_data=0, rsp_depth=0, req_ready=0, all sp=0, RR pointer=0.
- Reset mid-operation discards the in-flight response and all stacks.
- Latency: grant in cycle N, response registered at edge N+1 (rsp_valid in N+1).
- Throughput: one op per cycle while rsp_ready stays high.
- Response stays stable until rsp_valid&rsp_ready. While the response is stalled, req_ready is all-zero.
- req_ready is combinational from req_valid, the RR pointer, rsp_valid, rsp_ready and flush.
- RAM writes and pointer updates take effect at the grant edge. Reads use a synchronous (registered) RAM read at the grant edge.

## Structure
- Shared package VX_ti_pkg holds:
  - ti_stack_op_e (PUSH/POP/PEEK/CLEAR);
  - ti_stack_status_e (OK/UNDERFLOW/OVERFLOW);
  - the request struct {op, ray_id, data}.
- One sub-module: VX_ti_rr_arbiter, a parameterized round-robin grant with NUM_REQS inputs, a one-hot grant, the granted index, and an enable input.
- Stack storage is an inferred synchronous-read RAM inside this block. The pointer array is a flop vector.

## Test plan
- Reset, then req 0 pushes 0xA, 0xB to ray 3, then pops twice -> OK responses with rsp_data 0xB then 0xA; depths 1, 2, 1, 0.
- Requesters 0–3 all valid, rsp_ready=1 -> grants in order 0,1,2,3,0; one response per cycle with the matching rsp_req_idx.
- Push 32 entries to ray 5, then a 33rd -> OVERFLOW, depth 32, mem unchanged. POP on empty ray 2 -> UNDERFLOW, rsp_data 0.
- Hold rsp_ready=0 for 3 cycles with requests pending -> req_ready=0 and the response stays stable. Release -> the next grant follows on the following cycle.
- Push 0x11 to ray 1 in cycle N, then PEEK ray 1 in cycle N+1 -> returns 0x11, depth 1.
- Push to rays 0 and 7, assert flush -> all depths 0 and the next POP gives UNDERFLOW. Assert reset low mid-stream -> rsp_valid=0 immediately and pointers cleared.
